// File: rtl/pipo_load_arbiter_if.sv
// Handshake bundle between two load requesters and the shared-register arbiter.
// Requesters use the master view and the arbiter uses the slave view.
interface pipo_load_arbiter_if #(
  parameter int N = 8
);
  logic         req0;
  logic [N-1:0] d0;
  logic         req1;
  logic [N-1:0] d1;
  logic [N-1:0] reg_d;
  logic         reg_en;
  logic         ack0;
  logic         ack1;
  logic         owner;
  logic         busy;

  modport master (
    output req0, d0, req1, d1,
    input  reg_d, reg_en, ack0, ack1, owner, busy
  );

  modport slave (
    input  req0, d0, req1, d1,
    output reg_d, reg_en, ack0, ack1, owner, busy
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that drives one shared N-bit PIPO register with a
// one-cycle load pulse, then holds off new grants for HOLD_CYCLES cycles.
module pipo_load_arbiter #(
  parameter int N           = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic               clk,
  input logic               res,
  pipo_load_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   next_count;
  logic            grant;
  logic            sel;
  logic            last_grant;
  logic [N-1:0]    reg_d_q;
  logic            reg_en_q;
  logic            ack0_q;
  logic            ack1_q;
  logic            owner_q;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    next_state = state;
    next_count = count;
    grant      = 1'b0;
    sel        = last_grant;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant      = 1'b1;
          sel        = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (HOLD_CYCLES > 0) begin
          next_state = HOLD;
          next_count = HOLD_INIT;
        end else begin
          next_state = IDLE;
        end
      end
      HOLD: begin
        if (count == '0) begin
          next_state = IDLE;
        end else begin
          next_count = count - CW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Registered register-side outputs; reg_d keeps its value between loads.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      reg_d_q    <= '0;
      reg_en_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      reg_en_q <= grant;
      ack0_q   <= grant && !sel;
      ack1_q   <= grant && sel;
      if (grant) begin
        reg_d_q    <= sel ? bus.d1 : bus.d0;
        owner_q    <= sel;
        last_grant <= sel;
      end
    end
  end

  assign bus.reg_d  = reg_d_q;
  assign bus.reg_en = reg_en_q;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: directed handshake/reset scenarios plus a random
// phase scored against a grant-timing reference model through a queue.
module tb_pipo_load_arbiter;
  localparam int N     = 8;
  localparam int H     = 2;
  localparam int NCYC  = 2000;

  typedef struct {
    logic         owner;
    logic [N-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  pipo_load_arbiter_if #(.N(N)) bus ();
  pipo_load_arbiter_if #(.N(N)) bus_z ();

  pipo_load_arbiter #(.N(N), .HOLD_CYCLES(H)) dut (
    .clk(clk),
    .res(res),
    .bus(bus.slave)
  );

  pipo_load_arbiter #(.N(N), .HOLD_CYCLES(0)) dut_z (
    .clk(clk),
    .res(res),
    .bus(bus_z.slave)
  );

  // Stand-ins for the attached registers, n_res tied to ~res.
  logic [N-1:0] q;
  logic [N-1:0] q_z;
  always @(posedge clk or posedge res) begin
    if (res) begin
      q   <= '0;
      q_z <= '0;
    end else begin
      if (bus.reg_en) q <= bus.reg_d;
      if (bus_z.reg_en) q_z <= bus_z.reg_d;
    end
  end

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  bit   sb_on    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [N-1:0] v0,
                               input logic r1, input logic [N-1:0] v1);
    bus.req0 = r0;
    bus.d0   = v0;
    bus.req1 = r1;
    bus.d1   = v1;
  endtask

  // Monitor: every load the DUT presents must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_on) begin
      checkOutput("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'(0));
      checkOutput("ack_with_en", 32'(bus.ack0 | bus.ack1), 32'(bus.reg_en));
      if (bus.reg_en === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_extra_load", 32'(bus.reg_en), 32'(0));
        end else begin
          e = sb_q.pop_front();
          checkOutput("sb_owner", 32'(bus.owner), 32'(e.owner));
          checkOutput("sb_data", 32'(bus.reg_d), 32'(e.data));
          checkOutput("sb_ack0", 32'(bus.ack0), 32'(!e.owner));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          busy_cnt;
    int          ack1_at;
    logic        early_en;
    logic        late_en;
    logic        got;
    logic        any_en;
    int          load_cyc[$];
    logic [N-1:0] load_dat[$];
    int          edge_n;
    int          last_g;
    int          next_ok;
    logic        lg;
    logic        s;
    logic        exp_busy;
    logic [31:0] r;
    int          pushed;
    exp_t        e;

    applyStimulus(1'b0, '0, 1'b0, '0);
    bus_z.req0 = 1'b0;
    bus_z.d0   = '0;
    bus_z.req1 = 1'b0;
    bus_z.d1   = '0;

    #12;
    checkOutput("rst_reg_d", 32'(bus.reg_d), 32'(0));
    checkOutput("rst_reg_en", 32'(bus.reg_en), 32'(0));
    checkOutput("rst_ack0", 32'(bus.ack0), 32'(0));
    checkOutput("rst_ack1", 32'(bus.ack1), 32'(0));
    checkOutput("rst_owner", 32'(bus.owner), 32'(0));
    checkOutput("rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("rst_q", 32'(q), 32'(0));

    // Single req0 load, then req1 raised during hold, then a req0 pulse in hold.
    @(negedge clk) res = 1'b0;
    @(negedge clk) applyStimulus(1'b1, 8'hAA, 1'b0, 8'h55);
    @(negedge clk);
    checkOutput("t2_reg_en", 32'(bus.reg_en), 32'(1));
    checkOutput("t2_ack0", 32'(bus.ack0), 32'(1));
    checkOutput("t2_ack1", 32'(bus.ack1), 32'(0));
    checkOutput("t2_reg_d", 32'(bus.reg_d), 32'(8'hAA));
    checkOutput("t2_owner", 32'(bus.owner), 32'(0));
    checkOutput("t2_busy", 32'(bus.busy), 32'(1));
    applyStimulus(1'b0, 8'hAA, 1'b1, 8'h55);
    busy_cnt = 1;
    ack1_at  = -1;
    early_en = 1'b0;
    late_en  = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i <= 3) busy_cnt += int'(bus.busy);
      if (i == 1) checkOutput("t2_q", 32'(q), 32'(8'hAA));
      if (i < 4) early_en |= bus.reg_en;
      if (i >= 5) late_en |= bus.reg_en;
      if (bus.ack1 && ack1_at < 0) begin
        ack1_at  = i;
        bus.req1 = 1'b0;
      end
      if (i == 5) bus.req0 = 1'b1;
      if (i == 6) bus.req0 = 1'b0;
    end
    checkOutput("t2_busy_cycles", 32'(busy_cnt), 32'(3));
    checkOutput("t4_ack1_cycle", 32'(ack1_at), 32'(4));
    checkOutput("t4_no_load_in_hold", 32'(early_en), 32'(0));
    checkOutput("t5_pulse_ignored", 32'(late_en), 32'(0));
    checkOutput("t5_q_kept", 32'(q), 32'(8'h55));

    // Reset in the middle of a LOAD cycle aborts the load and the round-robin history.
    applyStimulus(1'b1, 8'hAA, 1'b0, 8'h55);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.ack0) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("t1_ack0_seen", 32'(got), 32'(1));
    bus.req0 = 1'b0;
    #2 res = 1'b1;
    #1;
    checkOutput("t1_reg_en", 32'(bus.reg_en), 32'(0));
    checkOutput("t1_ack0", 32'(bus.ack0), 32'(0));
    checkOutput("t1_ack1", 32'(bus.ack1), 32'(0));
    checkOutput("t1_busy", 32'(bus.busy), 32'(0));
    checkOutput("t1_owner", 32'(bus.owner), 32'(0));
    checkOutput("t1_reg_d", 32'(bus.reg_d), 32'(0));
    checkOutput("t1_q", 32'(q), 32'(0));
    @(negedge clk) res = 1'b0;
    any_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_en |= bus.reg_en;
    end
    checkOutput("t1_load_aborted", 32'(any_en), 32'(0));
    applyStimulus(1'b1, 8'hAA, 1'b1, 8'h55);
    @(negedge clk);
    checkOutput("t1_tie_ack0", 32'(bus.ack0), 32'(1));
    checkOutput("t1_tie_data", 32'(bus.reg_d), 32'(8'hAA));
    applyStimulus(1'b0, 8'hAA, 1'b0, 8'h55);
    repeat (5) @(negedge clk);

    // Both requesters re-requesting right after reset alternate every H+2 cycles.
    @(negedge clk) res = 1'b1;
    @(negedge clk) res = 1'b0;
    applyStimulus(1'b1, 8'hAA, 1'b1, 8'h55);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus.reg_en) begin
        load_cyc.push_back(i);
        load_dat.push_back(bus.reg_d);
      end
      bus.req0 = !bus.ack0;
      bus.req1 = !bus.ack1;
    end
    applyStimulus(1'b0, 8'hAA, 1'b0, 8'h55);
    checkOutput("t3_load_count", 32'(load_cyc.size()), 32'(4));
    for (int j = 0; j < 4 && j < load_cyc.size(); j++) begin
      checkOutput("t3_load_cycle", 32'(load_cyc[j]), 32'(1 + j * (H + 2)));
      checkOutput("t3_load_data", 32'(load_dat[j]), (j % 2 == 0) ? 32'(8'hAA) : 32'(8'h55));
    end
    repeat (6) @(negedge clk);

    // Zero hold window: a load every second cycle, busy only in the LOAD cycle.
    bus_z.d0   = 8'hAA;
    bus_z.d1   = 8'h55;
    bus_z.req0 = 1'b1;
    bus_z.req1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkOutput("t6_reg_en", 32'(bus_z.reg_en), 32'(i % 2));
      checkOutput("t6_busy", 32'(bus_z.busy), 32'(i % 2));
      if (i % 2 == 1)
        checkOutput("t6_reg_d", 32'(bus_z.reg_d), (i % 4 == 1) ? 32'(8'hAA) : 32'(8'h55));
      else
        checkOutput("t6_q", 32'(q_z), (i % 4 == 2) ? 32'(8'hAA) : 32'(8'h55));
      bus_z.req0 = !bus_z.ack0;
      bus_z.req1 = !bus_z.ack1;
    end
    bus_z.req0 = 1'b0;
    bus_z.req1 = 1'b0;

    // Random phase: grants happen at the earliest allowed edge with any request pending.
    @(negedge clk) res = 1'b1;
    @(negedge clk) res = 1'b0;
    sb_q.delete();
    sb_on   = 1'b1;
    edge_n  = 0;
    last_g  = -1000;
    next_ok = 0;
    lg      = 1'b1;
    pushed  = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      exp_busy = (edge_n - 1 >= last_g) && (edge_n - 1 <= last_g + H);
      checkOutput("rand_busy", 32'(bus.busy), 32'(exp_busy));
      if (bus.req0) begin
        if (bus.ack0 || $urandom_range(0, 19) == 0) bus.req0 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        r        = $urandom;
        bus.d0   = r[N-1:0];
        bus.req0 = 1'b1;
      end
      if (bus.req1) begin
        if (bus.ack1 || $urandom_range(0, 19) == 0) bus.req1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        r        = $urandom;
        bus.d1   = r[N-1:0];
        bus.req1 = 1'b1;
      end
      if (cyc >= NCYC - 8) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      if (edge_n >= next_ok && (bus.req0 || bus.req1)) begin
        s       = (bus.req0 && bus.req1) ? !lg : bus.req1;
        e.owner = s;
        e.data  = s ? bus.d1 : bus.d0;
        sb_q.push_back(e);
        pushed++;
        lg      = s;
        last_g  = edge_n;
        next_ok = edge_n + H + 2;
      end
      edge_n++;
    end
    repeat (8) @(negedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'(0));
    checkOutput("rand_activity", 32'(pushed > 50), 32'(1));
    sb_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
